jpeg_mcu_seq: RTL and testbench

Parametrised MCU block sequencer for the baseline JPEG decoder. It tracks which component (Y/Cb/Cr) and which 8x8 block coordinate the entropy decoder is currently producing, for monochrome, 4:4:4, 4:2:2 (H2V1) and 4:2:0 (H2V2) images. End of image is computed internally from the latched image dimensions, so no external end hint is needed. It also raises restart-interval markers. It sits between the Huffman/block decoder and the IDCT/output reorder stages.

---
 rtl/jpeg_mcu_seq_if.sv | 49 ++++
 rtl/jpeg_mcu_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_jpeg_mcu_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_mcu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_mcu_seq_if
// Purpose  : Bundles the image-control inputs and block-descriptor outputs of
//            the JPEG MCU block sequencer.
// Modports : master - drives image setup and end_of_block_i, observes outputs
//            slave  - the sequencer itself
// Signals  : img_start_i, img_width_i, img_height_i, img_mode_i,
//            restart_interval_i, end_of_block_i  (master -> slave)
//            block_valid_o, block_type_o, block_x_o, block_y_o, block_id_o,
//            mcu_last_o, restart_o, end_of_image_o, error_o (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface jpeg_mcu_seq_if #(
  parameter int COORD_W   = 16,
  parameter int RST_CNT_W = 16
) ();
  logic                     img_start_i;
  logic [15:0]              img_width_i;
  logic [15:0]              img_height_i;
  logic [2:0]               img_mode_i;
  logic [RST_CNT_W-1:0]     restart_interval_i;
  logic                     end_of_block_i;

  logic                     block_valid_o;
  logic [1:0]               block_type_o;
  logic [COORD_W-1:0]       block_x_o;
  logic [COORD_W-1:0]       block_y_o;
  logic [2+2*COORD_W-1:0]   block_id_o;
  logic                     mcu_last_o;
  logic                     restart_o;
  logic                     end_of_image_o;
  logic                     error_o;

  modport master (
    output img_start_i, img_width_i, img_height_i, img_mode_i,
           restart_interval_i, end_of_block_i,
    input  block_valid_o, block_type_o, block_x_o, block_y_o, block_id_o,
           mcu_last_o, restart_o, end_of_image_o, error_o
  );

  modport slave (
    input  img_start_i, img_width_i, img_height_i, img_mode_i,
           restart_interval_i, end_of_block_i,
    output block_valid_o, block_type_o, block_x_o, block_y_o, block_id_o,
           mcu_last_o, restart_o, end_of_image_o, error_o
  );
endinterface
`default_nettype wire

// File: rtl/jpeg_mcu_seq.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_mcu_seq
// Purpose  : MCU block sequencer for a baseline JPEG decoder. Tracks the
//            component (Y/Cb/Cr) and 8x8 block coordinate currently produced
//            by the entropy decoder for mono, 4:4:4, 4:2:2 and 4:2:0 images,
//            detects end of image from the latched dimensions and raises
//            restart-interval markers.
// Ports    : clk_i  - clock
//            rst_i  - asynchronous active-high reset
//            bus    - jpeg_mcu_seq_if.slave (image setup, end_of_block_i,
//                     block descriptor, mcu_last, restart, EOI, error)
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_mcu_seq #(
  parameter int COORD_W   = 16,
  parameter int RST_CNT_W = 16
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  jpeg_mcu_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [2:0] c_MODE_MONO = 3'd0;
  localparam logic [2:0] c_MODE_444  = 3'd1;
  localparam logic [2:0] c_MODE_420  = 3'd2;
  localparam logic [2:0] c_MODE_422  = 3'd3;

  localparam logic [1:0] c_TYPE_Y   = 2'd0;
  localparam logic [1:0] c_TYPE_CB  = 2'd1;
  localparam logic [1:0] c_TYPE_CR  = 2'd2;
  localparam logic [1:0] c_TYPE_EOF = 2'd3;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic [2:0]             r_mode;
  logic [19:0]            r_mcus_x;
  logic [19:0]            r_mcus_y;
  logic [2:0]             r_idx;
  logic [19:0]            r_mcu_x;
  logic [19:0]            r_mcu_y;
  logic [RST_CNT_W-1:0]   r_rst_cnt;

  logic                   r_valid;
  logic [1:0]             r_type;
  logic [COORD_W-1:0]     r_x;
  logic [COORD_W-1:0]     r_y;
  logic                   r_last;
  logic                   r_restart;
  logic                   r_eoi;
  logic                   r_error;

  // --------------------------------------------------------------------------
  // Geometry of the image being started (from the live inputs, so the grid
  // size is already registered on the cycle after img_start_i).
  // Sums are done in 20 bits so a 0xFFFF dimension cannot overflow.
  // --------------------------------------------------------------------------
  logic                   w_st_h2;
  logic                   w_st_v2;
  logic [19:0]            w_st_mcus_x;
  logic [19:0]            w_st_mcus_y;
  logic                   w_st_bad;

  assign w_st_h2 = (bus.img_mode_i == c_MODE_420) || (bus.img_mode_i == c_MODE_422);
  assign w_st_v2 = (bus.img_mode_i == c_MODE_420);

  assign w_st_mcus_x = w_st_h2 ? ((20'(bus.img_width_i)  + 20'd15) >> 4)
                               : ((20'(bus.img_width_i)  + 20'd7)  >> 3);
  assign w_st_mcus_y = w_st_v2 ? ((20'(bus.img_height_i) + 20'd15) >> 4)
                               : ((20'(bus.img_height_i) + 20'd7)  >> 3);

  assign w_st_bad = bus.img_mode_i[2] || (bus.img_width_i == 16'd0) ||
                    (bus.img_height_i == 16'd0);

  // --------------------------------------------------------------------------
  // MCU layout of the latched mode
  // --------------------------------------------------------------------------
  logic [2:0] w_bpm_m1;   // blocks per MCU minus one
  logic [2:0] w_ny;       // Y blocks per MCU
  logic       w_h2;
  logic       w_v2;

  always_comb begin
    w_bpm_m1 = 3'd0;
    w_ny     = 3'd1;
    w_h2     = 1'b0;
    w_v2     = 1'b0;
    case (r_mode)
      c_MODE_444: begin
        w_bpm_m1 = 3'd2;
      end
      c_MODE_420: begin
        w_bpm_m1 = 3'd5;
        w_ny     = 3'd4;
        w_h2     = 1'b1;
        w_v2     = 1'b1;
      end
      c_MODE_422: begin
        w_bpm_m1 = 3'd3;
        w_ny     = 3'd2;
        w_h2     = 1'b1;
      end
      default: begin
        w_bpm_m1 = 3'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Position of the block that follows the current one
  // --------------------------------------------------------------------------
  logic               w_mcu_end;
  logic               w_x_wrap;
  logic               w_last_mcu;
  logic [2:0]         w_n_idx;
  logic [19:0]        w_n_mcu_x;
  logic [19:0]        w_n_mcu_y;

  assign w_mcu_end  = (r_idx == w_bpm_m1);
  assign w_x_wrap   = (r_mcu_x == (r_mcus_x - 20'd1));
  assign w_last_mcu = w_x_wrap && (r_mcu_y == (r_mcus_y - 20'd1));

  assign w_n_idx   = w_mcu_end ? 3'd0 : (r_idx + 3'd1);
  assign w_n_mcu_x = w_mcu_end ? (w_x_wrap ? 20'd0 : (r_mcu_x + 20'd1)) : r_mcu_x;
  assign w_n_mcu_y = (w_mcu_end && w_x_wrap) ? (r_mcu_y + 20'd1) : r_mcu_y;

  // --------------------------------------------------------------------------
  // Descriptor of the next block. Coordinates wrap modulo 2^COORD_W.
  // --------------------------------------------------------------------------
  logic [COORD_W-1:0] w_mx_c;
  logic [COORD_W-1:0] w_my_c;
  logic [1:0]         w_n_type;
  logic [COORD_W-1:0] w_n_x;
  logic [COORD_W-1:0] w_n_y;
  logic               w_n_last;

  assign w_mx_c   = COORD_W'(w_n_mcu_x);
  assign w_my_c   = COORD_W'(w_n_mcu_y);
  assign w_n_last = (w_n_idx == w_bpm_m1);

  always_comb begin
    w_n_type = c_TYPE_Y;
    w_n_x    = w_mx_c;
    w_n_y    = w_my_c;
    if (w_n_idx < w_ny) begin
      // Luma: idx[0] picks the column, idx[1] the row inside the MCU
      if (w_h2) w_n_x = (w_mx_c << 1) | COORD_W'(w_n_idx[0]);
      if (w_v2) w_n_y = (w_my_c << 1) | COORD_W'(w_n_idx[1]);
    end else if (w_n_idx == w_ny) begin
      w_n_type = c_TYPE_CB;
    end else begin
      w_n_type = c_TYPE_CR;
    end
  end

  // --------------------------------------------------------------------------
  // Restart-interval counting (interval is sampled live)
  // --------------------------------------------------------------------------
  logic [RST_CNT_W-1:0] w_cnt_inc;
  logic                 w_rst_en;
  logic                 w_rst_hit;

  assign w_cnt_inc = r_rst_cnt + RST_CNT_W'(1);
  assign w_rst_en  = (bus.restart_interval_i != '0);
  assign w_rst_hit = w_rst_en && (w_cnt_inc == bus.restart_interval_i);

  // --------------------------------------------------------------------------
  // Sequencer state machine with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_mode    <= 3'd0;
      r_mcus_x  <= 20'd0;
      r_mcus_y  <= 20'd0;
      r_idx     <= 3'd0;
      r_mcu_x   <= 20'd0;
      r_mcu_y   <= 20'd0;
      r_rst_cnt <= '0;
      r_valid   <= 1'b0;
      r_type    <= 2'd0;
      r_x       <= '0;
      r_y       <= '0;
      r_last    <= 1'b0;
      r_restart <= 1'b0;
      r_eoi     <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_restart <= 1'b0;
      if (bus.img_start_i) begin
        // A coincident end_of_block_i is intentionally dropped here
        r_mode    <= bus.img_mode_i;
        r_mcus_x  <= w_st_mcus_x;
        r_mcus_y  <= w_st_mcus_y;
        r_idx     <= 3'd0;
        r_mcu_x   <= 20'd0;
        r_mcu_y   <= 20'd0;
        r_rst_cnt <= '0;
        r_type    <= c_TYPE_Y;
        r_x       <= '0;
        r_y       <= '0;
        r_eoi     <= 1'b0;
        r_error   <= w_st_bad;
        if (w_st_bad) begin
          r_state <= S_ERR;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_state <= S_RUN;
          r_valid <= 1'b1;
          // Only a mono MCU ends on its first block
          r_last  <= (bus.img_mode_i == c_MODE_MONO);
        end
      end else if (bus.end_of_block_i) begin
        case (r_state)
          S_RUN: begin
            if (w_mcu_end && w_last_mcu) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_type  <= c_TYPE_EOF;
              r_x     <= '0;
              r_y     <= '0;
              r_last  <= 1'b0;
              r_eoi   <= 1'b1;
            end else begin
              r_idx   <= w_n_idx;
              r_mcu_x <= w_n_mcu_x;
              r_mcu_y <= w_n_mcu_y;
              r_type  <= w_n_type;
              r_x     <= w_n_x;
              r_y     <= w_n_y;
              r_last  <= w_n_last;
              // Final MCU never reaches here, so it never raises a restart
              if (w_mcu_end && w_rst_en) begin
                if (w_rst_hit) begin
                  r_restart <= 1'b1;
                  r_rst_cnt <= '0;
                end else begin
                  r_rst_cnt <= w_cnt_inc;
                end
              end
            end
          end
          S_DONE: begin
            r_error <= 1'b1;
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.block_valid_o  = r_valid;
  assign bus.block_type_o   = r_type;
  assign bus.block_x_o      = r_x;
  assign bus.block_y_o      = r_y;
  assign bus.block_id_o     = {r_type, r_y, r_x};
  assign bus.mcu_last_o     = r_last;
  assign bus.restart_o      = r_restart;
  assign bus.end_of_image_o = r_eoi;
  assign bus.error_o        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_mcu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_mcu_seq
// Purpose  : Self-checking bench for jpeg_mcu_seq. Expected block sequences
//            come from a fixed vector table and from a nested-loop image
//            model that fills a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_mcu_seq;

  localparam int COORD_W   = 16;
  localparam int RST_CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  jpeg_mcu_seq_if #(.COORD_W(COORD_W), .RST_CNT_W(RST_CNT_W)) bus ();

  jpeg_mcu_seq #(.COORD_W(COORD_W), .RST_CNT_W(RST_CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  t;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
    logic        rst;   // restart_o expected after this block's end
  } blk_t;

  blk_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_img(input int mode, input int w, input int h, input int ri);
    @(negedge clk);
    bus.img_mode_i         = 3'(mode);
    bus.img_width_i        = 16'(w);
    bus.img_height_i       = 16'(h);
    bus.restart_interval_i = 16'(ri);
    bus.img_start_i        = 1'b1;
    @(negedge clk);
    bus.img_start_i        = 1'b0;
  endtask

  task automatic pulse_eob();
    bus.end_of_block_i = 1'b1;
    @(negedge clk);
    bus.end_of_block_i = 1'b0;
  endtask

  function automatic void push(input int t, input int x, input int y, input bit last, input bit r);
    blk_t e;
    e.t = 2'(t); e.x = 16'(x); e.y = 16'(y); e.last = last; e.rst = r;
    sb.push_back(e);
  endfunction

  // Independent image model: walk MCUs in raster order and list their blocks
  function automatic void build(input int mode, input int w, input int h, input int ri);
    int hh, vv, nx, ny, mcu;
    bit fin, r;
    hh  = (mode == 2 || mode == 3) ? 2 : 1;
    vv  = (mode == 2) ? 2 : 1;
    nx  = (w + 8*hh - 1) / (8*hh);
    ny  = (h + 8*vv - 1) / (8*vv);
    mcu = 0;
    for (int my = 0; my < ny; my++) begin
      for (int mx = 0; mx < nx; mx++) begin
        mcu++;
        fin = (mx == nx-1) && (my == ny-1);
        r   = (ri != 0) && (mcu % ri == 0) && !fin;
        case (mode)
          0: push(0, mx, my, 1, r);
          1: begin
            push(0, mx, my, 0, 0); push(1, mx, my, 0, 0); push(2, mx, my, 1, r);
          end
          3: begin
            push(0, 2*mx, my, 0, 0); push(0, 2*mx+1, my, 0, 0);
            push(1, mx, my, 0, 0);   push(2, mx, my, 1, r);
          end
          default: begin
            push(0, 2*mx, 2*my, 0, 0);   push(0, 2*mx+1, 2*my, 0, 0);
            push(0, 2*mx, 2*my+1, 0, 0); push(0, 2*mx+1, 2*my+1, 0, 0);
            push(1, mx, my, 0, 0);       push(2, mx, my, 1, r);
          end
        endcase
      end
    end
  endfunction

  task automatic chk_blk(input blk_t e);
    chk("valid", bus.block_valid_o, 1);
    chk("type",  bus.block_type_o, e.t);
    chk("x",     bus.block_x_o, e.x);
    chk("y",     bus.block_y_o, e.y);
    chk("last",  bus.mcu_last_o, e.last);
    chk("id",    bus.block_id_o, {e.t, e.y, e.x});
  endtask

  task automatic chk_eoi();
    chk("eoi",       bus.end_of_image_o, 1);
    chk("eoi_valid", bus.block_valid_o, 0);
    chk("eoi_type",  bus.block_type_o, 3);
  endtask

  // Drain the scoreboard, one end_of_block_i per cycle
  task automatic consume();
    blk_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk_blk(e);
      pulse_eob();
      chk("restart", bus.restart_o, e.rst);
    end
    chk_eoi();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},   bus.block_valid_o, 0);
    chk({tag, "_type"},    bus.block_type_o, 0);
    chk({tag, "_x"},       bus.block_x_o, 0);
    chk({tag, "_y"},       bus.block_y_o, 0);
    chk({tag, "_last"},    bus.mcu_last_o, 0);
    chk({tag, "_restart"}, bus.restart_o, 0);
    chk({tag, "_eoi"},     bus.end_of_image_o, 0);
    chk({tag, "_error"},   bus.error_o, 0);
  endtask

  task automatic bad_image(input int mode, input int w, input int h);
    start_img(mode, w, h, 0);
    chk("bad_error", bus.error_o, 1);
    chk("bad_valid", bus.block_valid_o, 0);
    for (int i = 0; i < 10; i++) begin
      pulse_eob();
      chk("bad_valid_eob", bus.block_valid_o, 0);
      chk("bad_error_eob", bus.error_o, 1);
    end
  endtask

  blk_t vec[6];

  initial begin
    // 4:2:0 16x16 expected descriptor table
    vec[0] = '{t: 2'd0, x: 16'd0, y: 16'd0, last: 1'b0, rst: 1'b0};
    vec[1] = '{t: 2'd0, x: 16'd1, y: 16'd0, last: 1'b0, rst: 1'b0};
    vec[2] = '{t: 2'd0, x: 16'd0, y: 16'd1, last: 1'b0, rst: 1'b0};
    vec[3] = '{t: 2'd0, x: 16'd1, y: 16'd1, last: 1'b0, rst: 1'b0};
    vec[4] = '{t: 2'd1, x: 16'd0, y: 16'd0, last: 1'b0, rst: 1'b0};
    vec[5] = '{t: 2'd2, x: 16'd0, y: 16'd0, last: 1'b1, rst: 1'b0};

    bus.img_start_i        = 1'b0;
    bus.img_width_i        = 16'd0;
    bus.img_height_i       = 16'd0;
    bus.img_mode_i         = 3'd0;
    bus.restart_interval_i = 16'd0;
    bus.end_of_block_i     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    pulse_eob();
    chk_all_zero("idle");

    // Table-driven 4:2:0 16x16
    start_img(2, 16, 16, 0);
    for (int i = 0; i < 6; i++) begin
      chk_blk(vec[i]);
      pulse_eob();
      chk("tbl_restart", bus.restart_o, 0);
    end
    chk_eoi();

    // Model-driven images
    start_img(3, 24, 8, 0);    build(3, 24, 8, 0);    consume();
    start_img(1, 16, 16, 2);   build(1, 16, 16, 2);   consume();
    start_img(2, 40, 24, 3);   build(2, 40, 24, 3);   consume();
    start_img(3, 17, 9, 1);    build(3, 17, 9, 1);    consume();
    start_img(1, 8, 16, 0);    build(1, 8, 16, 0);    consume();
    start_img(0, 65535, 8, 0); build(0, 65535, 8, 0); consume();

    // Mono 8x8, extra block after end -> sticky error, cleared by start
    start_img(0, 8, 8, 0); build(0, 8, 8, 0); consume();
    pulse_eob();
    chk("post_eoi_error", bus.error_o, 1);
    chk("post_eoi_eoi",   bus.end_of_image_o, 1);
    @(negedge clk);
    chk("sticky_error", bus.error_o, 1);
    start_img(1, 8, 8, 0);
    chk("restart_clears_error", bus.error_o, 0);
    chk("restart_clears_eoi",   bus.end_of_image_o, 0);
    build(1, 8, 8, 0); consume();

    // Restart with img_start_i coincident with end_of_block_i
    start_img(2, 32, 16, 0);
    repeat (3) pulse_eob();
    bus.img_start_i    = 1'b1;
    bus.end_of_block_i = 1'b1;
    @(negedge clk);
    bus.img_start_i    = 1'b0;
    bus.end_of_block_i = 1'b0;
    chk("coinc_error", bus.error_o, 0);
    build(2, 32, 16, 0); consume();

    // Asynchronous reset mid-image
    start_img(2, 32, 16, 0);
    repeat (2) pulse_eob();
    chk("pre_rst_y", bus.block_y_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async");
    @(negedge clk);
    rst = 1'b0;
    pulse_eob();
    chk_all_zero("post_rst_idle");

    // Unsupported configurations
    bad_image(5, 16, 16);
    bad_image(2, 0, 16);
    bad_image(1, 16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
